// File: rtl/shift_reg_pkg.sv
// Shared types for the universal shift register: per-step operation codes and FSM states.
package shift_reg_pkg;

  typedef enum logic [2:0] {
    SR_HOLD = 3'd0,
    SR_SHL  = 3'd1,
    SR_SHR  = 3'd2,
    SR_SAR  = 3'd3,
    SR_ROL  = 3'd4,
    SR_ROR  = 3'd5
  } sr_mode_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } sr_state_t;

endpackage

// File: rtl/shift_unit.sv
// Combinational single-step shift/rotate datapath; reusable by serial/parallel converters.
module shift_unit
  import shift_reg_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] q,
  input  sr_mode_t         mode,
  input  logic             ser_in,
  output logic [WIDTH-1:0] q_next
);

  // Codes 6 and 7 have no enum label and fall through to HOLD.
  always_comb begin
    q_next = q;
    case (mode)
      SR_SHL:  q_next = {q[WIDTH-2:0], ser_in};
      SR_SHR:  q_next = {ser_in, q[WIDTH-1:1]};
      SR_SAR:  q_next = {q[WIDTH-1], q[WIDTH-1:1]};
      SR_ROL:  q_next = {q[WIDTH-2:0], q[WIDTH-1]};
      SR_ROR:  q_next = {q[0], q[WIDTH-1:1]};
      default: q_next = q;
    endcase
  end

endmodule

// File: rtl/shift_reg_univ.sv
// Universal shift register: parallel load plus a counted multi-step shift/rotate sequence.
module shift_reg_univ
  import shift_reg_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             write,
  input  logic [WIDTH-1:0] inp,
  input  logic [2:0]       mode,
  input  logic             ser_in,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  output logic [WIDTH-1:0] q,
  output logic             ser_out_l,
  output logic             ser_out_r,
  output logic             busy,
  output logic             done
);

  sr_state_t        state;
  sr_state_t        state_next;
  sr_mode_t         mode_q;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] step_q;

  shift_unit #(.WIDTH(WIDTH)) u_shift_unit (
    .q      (q),
    .mode   (mode_q),
    .ser_in (ser_in),
    .q_next (step_q)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (!write && start)
          state_next = (count == '0) ? ST_DONE : ST_SHIFT;
      end
      ST_SHIFT: begin
        if (cnt == CNT_W'(1)) state_next = ST_DONE;
      end
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Both flags decode the state flop directly, so they carry no combinational input paths.
  always_comb begin
    busy = (state == ST_SHIFT);
    done = (state == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q      <= '0;
      cnt    <= '0;
      mode_q <= SR_HOLD;
    end else begin
      case (state)
        ST_IDLE: begin
          if (write) begin
            q <= inp;
          end else if (start && count != '0) begin
            mode_q <= sr_mode_t'(mode);
            cnt    <= count;
          end
        end
        ST_SHIFT: begin
          q   <= step_q;
          cnt <= cnt - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign ser_out_l = q[WIDTH-1];
  assign ser_out_r = q[0];

endmodule

// File: tb/tb_shift_reg_univ.sv
// Directed bench for shift_reg_univ: expected results are queued at launch and checked on each done pulse.
module tb_shift_reg_univ;

  logic       clk = 1'b0;
  logic       reset;
  logic       write;
  logic [7:0] inp;
  logic [2:0] mode;
  logic       ser_in;
  logic       start;
  logic [3:0] count;
  logic [7:0] q;
  logic       ser_out_l;
  logic       ser_out_r;
  logic       busy;
  logic       done;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    logic [7:0] q;
    int         cyc;
  } exp_t;

  exp_t sb[$];

  shift_reg_univ #(.WIDTH(8), .CNT_W(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .write     (write),
    .inp       (inp),
    .mode      (mode),
    .ser_in    (ser_in),
    .start     (start),
    .count     (count),
    .q         (q),
    .ser_out_l (ser_out_l),
    .ser_out_r (ser_out_r),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest queued expectation in value and timing.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_done", 32'(done), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("done_q", 32'(q), 32'(e.q));
        checkOutput("done_cycle", 32'(cyc), 32'(e.cyc));
        checkOutput("busy_in_done", 32'(busy), 32'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic w, input logic [7:0] d, input logic s,
                               input logic [2:0] m, input logic [3:0] n, input logic si);
    write  = w;
    inp    = d;
    start  = s;
    mode   = m;
    count  = n;
    ser_in = si;
    tick();
    write  = 1'b0;
    start  = 1'b0;
  endtask

  task automatic load(input logic [7:0] d);
    applyStimulus(1'b1, d, 1'b0, 3'd0, 4'd0, 1'b0);
    checkOutput("load_q", 32'(q), 32'(d));
  endtask

  task automatic launch(input logic [2:0] m, input logic [3:0] n, input logic si,
                        input logic [7:0] exp_q, input bit expect_done);
    exp_t e;
    applyStimulus(1'b0, 8'h00, 1'b1, m, n, si);
    if (expect_done) begin
      e.q   = exp_q;
      e.cyc = cyc + int'(n);
      sb.push_back(e);
    end
  endtask

  task automatic waitDone();
    for (int i = 0; i < 40; i++) begin
      if (sb.size() == 0) break;
      tick();
    end
    if (sb.size() != 0) begin
      checkOutput("done_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1; write = 1'b0; inp = '0; mode = '0; ser_in = 1'b0; start = 1'b0; count = '0;
    tick();
    tick();
    checkOutput("reset_q", 32'(q), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    reset = 1'b0;

    load(8'b00100010);
    checkOutput("load_busy", 32'(busy), 32'd0);
    checkOutput("load_done", 32'(done), 32'd0);
    checkOutput("ser_out_l_0", 32'(ser_out_l), 32'd0);
    checkOutput("ser_out_r_0", 32'(ser_out_r), 32'd0);

    // Rotate left by 3, following each intermediate step.
    load(8'b10100001);
    checkOutput("ser_out_l_1", 32'(ser_out_l), 32'd1);
    checkOutput("ser_out_r_1", 32'(ser_out_r), 32'd1);
    launch(3'd4, 4'd3, 1'b0, 8'b00001101, 1'b1);
    checkOutput("rol_e0_q", 32'(q), 32'b10100001);
    checkOutput("rol_e0_busy", 32'(busy), 32'd1);
    tick();
    checkOutput("rol_s1", 32'(q), 32'b01000011);
    checkOutput("rol_s1_busy", 32'(busy), 32'd1);
    tick();
    checkOutput("rol_s2", 32'(q), 32'b10000110);
    checkOutput("rol_s2_busy", 32'(busy), 32'd1);
    tick();
    checkOutput("rol_s3", 32'(q), 32'b00001101);
    checkOutput("rol_s3_busy", 32'(busy), 32'd0);
    waitDone();

    load(8'b10100001);
    launch(3'd3, 4'd2, 1'b0, 8'b11101000, 1'b1);
    waitDone();

    load(8'b00011110);
    launch(3'd1, 4'd3, 1'b1, 8'b11110111, 1'b1);
    waitDone();

    // Zero-step launch goes straight to DONE.
    load(8'h5A);
    launch(3'd1, 4'd0, 1'b1, 8'h5A, 1'b1);
    checkOutput("cnt0_busy", 32'(busy), 32'd0);
    waitDone();

    load(8'hFF);
    launch(3'd2, 4'd15, 1'b0, 8'h00, 1'b1);
    waitDone();

    // Reserved code behaves as HOLD.
    load(8'hC3);
    launch(3'd6, 4'd2, 1'b1, 8'hC3, 1'b1);
    waitDone();

    load(8'b10100001);
    launch(3'd4, 4'd3, 1'b0, 8'b00001101, 1'b1);
    applyStimulus(1'b1, 8'hAA, 1'b1, 3'd2, 4'd5, 1'b1);
    checkOutput("ign_s1", 32'(q), 32'b01000011);
    waitDone();

    // write and start together in IDLE: load wins, no sequence starts.
    applyStimulus(1'b1, 8'h3C, 1'b1, 3'd1, 4'd2, 1'b1);
    checkOutput("ws_q", 32'(q), 32'h3C);
    checkOutput("ws_busy", 32'(busy), 32'd0);
    tick();
    checkOutput("ws_busy2", 32'(busy), 32'd0);
    checkOutput("ws_done2", 32'(done), 32'd0);
    checkOutput("ws_q2", 32'(q), 32'h3C);

    // Reset during step 2 of a 5-step ROR abandons the sequence silently.
    load(8'h81);
    launch(3'd5, 4'd5, 1'b0, 8'h00, 1'b0);
    tick();
    checkOutput("ror_s1", 32'(q), 32'hC0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("rst_mid_q", 32'(q), 32'd0);
    checkOutput("rst_mid_busy", 32'(busy), 32'd0);
    checkOutput("rst_mid_done", 32'(done), 32'd0);
    repeat (6) tick();

    load(8'h81);
    launch(3'd5, 4'd2, 1'b0, 8'h60, 1'b1);
    waitDone();
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
